// File: rtl/frame_buffer_pkg.sv
// ============================================================================
// Module      : frame_buffer_pkg
// Description : Shared slot-state type and slot base-address helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package frame_buffer_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_WRITING = 2'd1,
        SLOT_READY   = 2'd2,
        SLOT_READING = 2'd3
    } slot_state_t;

    // Callers truncate to their own address width, giving modulo wrap-around.
    function automatic logic [63:0] slot_addr(input logic [63:0] base,
                                              input logic [63:0] stride,
                                              input logic [63:0] idx);
        return base + idx * stride;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_slot_sched.sv
// ============================================================================
// Module      : frame_slot_sched
// Description : Frame-buffer slot scheduler between one writer and one reader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module frame_slot_sched
    import frame_buffer_pkg::*;
#(
    parameter logic [63:0] START_ADDR      = 64'd0,
    parameter int          FRAMES_AMOUNT   = 3,
    parameter logic [63:0] BYTES_PER_FRAME = 64'd4147200,
    parameter int          ADDR_WIDTH      = 32,
    parameter int          DROP_CNT_WIDTH  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      wr_req_i,
    input  logic                      wr_done_i,
    input  logic                      wr_abort_i,
    output logic                      wr_gnt_o,
    output logic [ADDR_WIDTH-1:0]     wr_addr_o,
    input  logic                      rd_req_i,
    output logic                      rd_gnt_o,
    output logic [ADDR_WIDTH-1:0]     rd_addr_o,
    output logic                      rd_new_o,
    output logic                      rd_valid_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

    localparam int IDX_W = (FRAMES_AMOUNT > 1) ? $clog2(FRAMES_AMOUNT) : 1;
    localparam logic [ADDR_WIDTH-1:0] C_START = ADDR_WIDTH'(START_ADDR);

    typedef slot_state_t [FRAMES_AMOUNT-1:0] slot_vec_t;

    function automatic logic [FRAMES_AMOUNT-1:0] match_mask(input slot_vec_t   slots,
                                                            input slot_state_t st);
        logic [FRAMES_AMOUNT-1:0] m;
        m = '0;
        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
            m[i] = (slots[i] == st);
        end
        return m;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_free(input slot_vec_t slots);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = FRAMES_AMOUNT - 1; i >= 0; i--) begin
            if (slots[i] == SLOT_FREE) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [IDX_W-1:0] idx);
        return ADDR_WIDTH'(slot_addr(START_ADDR, BYTES_PER_FRAME, 64'(idx)));
    endfunction

    slot_vec_t                 r_slots;
    logic                      r_wr_gnt;
    logic [ADDR_WIDTH-1:0]     r_wr_addr;
    logic                      r_rd_gnt;
    logic [ADDR_WIDTH-1:0]     r_rd_addr;
    logic                      r_rd_new;
    logic                      r_rd_valid;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

    slot_vec_t                 w_slots;
    logic                      w_drop_inc;
    logic                      w_wr_gnt;
    logic [IDX_W-1:0]          w_wr_idx;
    logic [IDX_W-1:0]          w_rd_idx;
    logic                      w_rd_new;
    logic                      w_rd_valid;
    logic                      w_has_writing;
    logic                      w_has_free;
    logic                      w_has_ready;
    logic                      w_has_reading;

    // Events resolve in order: done/abort, then write request, then read request.
    always_comb begin
        w_slots       = r_slots;
        w_drop_inc    = 1'b0;
        w_wr_gnt      = 1'b0;
        w_wr_idx      = '0;
        w_rd_idx      = '0;
        w_rd_new      = 1'b0;
        w_rd_valid    = 1'b0;
        w_has_writing = |match_mask(r_slots, SLOT_WRITING);

        if (wr_done_i && w_has_writing) begin
            for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                if (r_slots[i] == SLOT_READY) begin
                    w_slots[i] = SLOT_FREE;
                    w_drop_inc = 1'b1;
                end else if (r_slots[i] == SLOT_WRITING) begin
                    w_slots[i] = SLOT_READY;
                end
            end
        end else if (wr_abort_i && w_has_writing) begin
            for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                if (r_slots[i] == SLOT_WRITING) begin
                    w_slots[i] = SLOT_FREE;
                end
            end
        end

        if (wr_req_i) begin
            for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                if (w_slots[i] == SLOT_WRITING) begin
                    w_slots[i] = SLOT_FREE;
                end
            end
        end
        w_has_free = |match_mask(w_slots, SLOT_FREE);
        if (wr_req_i && w_has_free) begin
            w_wr_idx          = lowest_free(w_slots);
            w_slots[w_wr_idx] = SLOT_WRITING;
            w_wr_gnt          = 1'b1;
        end

        w_has_ready   = |match_mask(w_slots, SLOT_READY);
        w_has_reading = |match_mask(w_slots, SLOT_READING);
        if (rd_req_i) begin
            if (w_has_ready) begin
                for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                    if (w_slots[i] == SLOT_READING) begin
                        w_slots[i] = SLOT_FREE;
                    end else if (w_slots[i] == SLOT_READY) begin
                        w_slots[i] = SLOT_READING;
                        w_rd_idx   = IDX_W'(i);
                    end
                end
                w_rd_new   = 1'b1;
                w_rd_valid = 1'b1;
            end else if (w_has_reading) begin
                for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                    if (w_slots[i] == SLOT_READING) begin
                        w_rd_idx = IDX_W'(i);
                    end
                end
                w_rd_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                r_slots[i] <= SLOT_FREE;
            end
            r_wr_gnt   <= 1'b0;
            r_wr_addr  <= C_START;
            r_rd_gnt   <= 1'b0;
            r_rd_addr  <= C_START;
            r_rd_new   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_slots    <= w_slots;
            r_wr_gnt   <= w_wr_gnt;
            r_rd_gnt   <= rd_req_i;
            r_rd_new   <= w_rd_new;
            r_rd_valid <= w_rd_valid;
            if (w_wr_gnt) begin
                r_wr_addr <= slot_base(w_wr_idx);
            end
            if (rd_req_i) begin
                r_rd_addr <= slot_base(w_rd_idx);
            end
            if (w_drop_inc && (r_drop_cnt != {DROP_CNT_WIDTH{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign wr_gnt_o   = r_wr_gnt;
    assign wr_addr_o  = r_wr_addr;
    assign rd_gnt_o   = r_rd_gnt;
    assign rd_addr_o  = r_rd_addr;
    assign rd_new_o   = r_rd_new;
    assign rd_valid_o = r_rd_valid;
    assign drop_cnt_o = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_frame_slot_sched.sv
// ============================================================================
// Module      : tb_frame_slot_sched
// Description : Scoreboard bench for frame_slot_sched (3 slots, 4 KiB stride).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_frame_slot_sched;

    localparam logic [31:0] C_BASE = 32'h1000_0000;
    localparam logic [31:0] C_S1   = 32'h1000_1000;
    localparam logic [31:0] C_S2   = 32'h1000_2000;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        wr_req_i = 1'b0;
    logic        wr_done_i = 1'b0;
    logic        wr_abort_i = 1'b0;
    logic        rd_req_i = 1'b0;
    logic        wr_gnt_o;
    logic [31:0] wr_addr_o;
    logic        rd_gnt_o;
    logic [31:0] rd_addr_o;
    logic        rd_new_o;
    logic        rd_valid_o;
    logic [15:0] drop_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_wr[$];
    logic [33:0] exp_rd[$];   // {addr, new, valid}

    frame_slot_sched #(
        .START_ADDR     (64'h1000_0000),
        .FRAMES_AMOUNT  (3),
        .BYTES_PER_FRAME(64'h1000),
        .ADDR_WIDTH     (32),
        .DROP_CNT_WIDTH (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .wr_req_i   (wr_req_i),
        .wr_done_i  (wr_done_i),
        .wr_abort_i (wr_abort_i),
        .wr_gnt_o   (wr_gnt_o),
        .wr_addr_o  (wr_addr_o),
        .rd_req_i   (rd_req_i),
        .rd_gnt_o   (rd_gnt_o),
        .rd_addr_o  (rd_addr_o),
        .rd_new_o   (rd_new_o),
        .rd_valid_o (rd_valid_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Grants are popped against the scoreboard half a cycle after the active edge.
    always @(negedge clk_i) begin
        logic [31:0] ew;
        logic [33:0] er;
        if (wr_gnt_o) begin
            n_vec++;
            if (exp_wr.size() == 0) begin
                n_err++;
                $display("FAIL wr_gnt_unexpected: got addr=%h, required no grant", wr_addr_o);
            end else begin
                ew = exp_wr.pop_front();
                if (wr_addr_o !== ew) begin
                    n_err++;
                    $display("FAIL wr_addr: got %h, required %h", wr_addr_o, ew);
                end
            end
        end
        if (rd_gnt_o) begin
            n_vec++;
            if (exp_rd.size() == 0) begin
                n_err++;
                $display("FAIL rd_gnt_unexpected: got addr=%h new=%b valid=%b, required no grant",
                         rd_addr_o, rd_new_o, rd_valid_o);
            end else begin
                er = exp_rd.pop_front();
                if ({rd_addr_o, rd_new_o, rd_valid_o} !== er) begin
                    n_err++;
                    $display("FAIL rd_grant: got addr=%h new=%b valid=%b, required addr=%h new=%b valid=%b",
                             rd_addr_o, rd_new_o, rd_valid_o, er[33:2], er[1], er[0]);
                end
            end
        end
    end

    task automatic drive(input logic wr, input logic done, input logic ab, input logic rd);
        wr_req_i   = wr;
        wr_done_i  = done;
        wr_abort_i = ab;
        rd_req_i   = rd;
        @(negedge clk_i);
        wr_req_i   = 1'b0;
        wr_done_i  = 1'b0;
        wr_abort_i = 1'b0;
        rd_req_i   = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4 && (exp_wr.size() != 0 || exp_rd.size() != 0); i++) begin
            @(negedge clk_i);
        end
        n_vec++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing_grants: got %0d wr and %0d rd outstanding, required 0",
                     name, exp_wr.size(), exp_rd.size());
            exp_wr.delete();
            exp_rd.delete();
        end
    endtask

    task automatic apply_reset(input string name);
        rst_n_i = 1'b0;
        #1;
        n_vec++;
        if ({wr_gnt_o, rd_gnt_o, rd_new_o, rd_valid_o} !== 4'b0 || wr_addr_o !== C_BASE ||
            rd_addr_o !== C_BASE || drop_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL %s_reset_values: got wg=%b rg=%b new=%b val=%b wa=%h ra=%h drop=%0d, required 0 0 0 0 %h %h 0",
                     name, wr_gnt_o, rd_gnt_o, rd_new_o, rd_valid_o, wr_addr_o, rd_addr_o,
                     drop_cnt_o, C_BASE, C_BASE);
        end
        wr_req_i   = 1'b0;
        wr_done_i  = 1'b0;
        wr_abort_i = 1'b0;
        rd_req_i   = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        apply_reset("initial");
    endtask

    task automatic test_read_empty();
        exp_rd.push_back({C_BASE, 1'b0, 1'b0});
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drain("read_empty");
    endtask

    task automatic test_basic();
        exp_wr.push_back(C_BASE);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        exp_rd.push_back({C_BASE, 1'b1, 1'b1});
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        exp_rd.push_back({C_BASE, 1'b0, 1'b1});
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drain("basic");
    endtask

    task automatic test_drop();
        logic [31:0] addrs [3];
        addrs[0] = C_S1;
        addrs[1] = C_S2;
        addrs[2] = C_S1;
        for (int i = 0; i < 3; i++) begin
            exp_wr.push_back(addrs[i]);
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b1, 1'b0, 1'b0);
        end
        n_vec++;
        if (drop_cnt_o !== 16'd2) begin
            n_err++;
            $display("FAIL drop_cnt: got %0d, required 2", drop_cnt_o);
        end
        exp_rd.push_back({C_S1, 1'b1, 1'b1});
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drain("drop");
    endtask

    task automatic test_same_cycle();
        exp_wr.push_back(C_BASE);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        exp_rd.push_back({C_BASE, 1'b1, 1'b1});
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drain("same_cycle");
        n_vec++;
        if (drop_cnt_o !== 16'd2) begin
            n_err++;
            $display("FAIL same_cycle_drop: got %0d, required 2", drop_cnt_o);
        end
    endtask

    task automatic test_abort();
        apply_reset("abort");
        exp_wr.push_back(C_BASE);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        exp_rd.push_back({C_BASE, 1'b0, 1'b0});
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        exp_wr.push_back(C_BASE);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drain("abort");
    endtask

    task automatic test_reset_mid();
        apply_reset("mid_pre");
        exp_wr.push_back(C_BASE);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        exp_rd.push_back({C_BASE, 1'b1, 1'b1});
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        exp_wr.push_back(C_S1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drain("mid_setup");
        wr_req_i = 1'b1;
        rd_req_i = 1'b1;
        apply_reset("mid");
        repeat (3) @(negedge clk_i);
        exp_wr.push_back(C_BASE);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drain("mid_after");
    endtask

    task automatic test_back_to_back();
        exp_wr.push_back(C_S1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        exp_wr.push_back(C_BASE);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (drop_cnt_o !== 16'd1) begin
            n_err++;
            $display("FAIL b2b_drop: got %0d, required 1", drop_cnt_o);
        end
        exp_rd.push_back({C_S1, 1'b1, 1'b1});
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (drop_cnt_o !== 16'd1) begin
            n_err++;
            $display("FAIL ignored_done_drop: got %0d, required 1", drop_cnt_o);
        end
        exp_rd.push_back({C_S1, 1'b0, 1'b1});
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_read_empty();
        test_basic();
        test_drop();
        test_same_cycle();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/frame_slot_sched.md
FRAME_SLOT_SCHED -- requirements
Module: frame_slot_sched

Interface
REQ-001 SHALL have parameter START_ADDR, default 0, byte address of slot 0.
REQ-002 SHALL have parameter FRAMES_AMOUNT, default 3, number of frame slots; legal range 3..8.
REQ-003 SHALL have parameter BYTES_PER_FRAME, default 4147200, slot stride in bytes.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-005 SHALL have parameter DROP_CNT_WIDTH, default 16, width of the dropped-frame counter.
REQ-006 clk_i  in  1  single clock; all logic on its rising edge.
REQ-007 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-008 wr_req_i  in  1  writer start-of-frame slot request, single-cycle pulse.
REQ-009 wr_done_i  in  1  writer completed its current frame.
REQ-010 wr_abort_i  in  1  writer discarded its current frame.
REQ-011 wr_gnt_o  out  1  one-cycle pulse; wr_addr_o is valid with it.
REQ-012 wr_addr_o  out  ADDR_WIDTH  base address of the slot granted to the writer.
REQ-013 rd_req_i  in  1  reader start-of-frame slot request, single-cycle pulse.
REQ-014 rd_gnt_o  out  1  one-cycle pulse; rd_addr_o, rd_new_o and rd_valid_o are valid with it.
REQ-015 rd_addr_o  out  ADDR_WIDTH  base address of the slot the reader is to scan.
REQ-016 rd_new_o  out  1  1 = slot not previously given to the reader; 0 = repeat.
REQ-017 rd_valid_o  out  1  0 = no completed frame exists yet; reader outputs blank.
REQ-018 drop_cnt_o  out  DROP_CNT_WIDTH  count of completed frames superseded before being read; saturating.

Function
REQ-019 SHALL hold one state per slot: FREE, WRITING, READY, READING.
REQ-020 Slot i base address SHALL be START_ADDR + i*BYTES_PER_FRAME, computed in ADDR_WIDTH bits (modulo 2^ADDR_WIDTH).
REQ-021 At most one slot SHALL be WRITING, at most one READY and at most one READING.
REQ-022 On wr_req_i, any WRITING slot SHALL go to FREE, and the lowest-index FREE slot SHALL go to WRITING.
REQ-023 wr_gnt_o and wr_addr_o SHALL assert exactly one cycle after wr_req_i.
REQ-024 On wr_done_i with a WRITING slot, that slot SHALL become READY, and any previous READY slot SHALL become FREE with drop_cnt_o +1.
REQ-025 On wr_abort_i, the WRITING slot SHALL become FREE; wr_done_i or wr_abort_i with no WRITING slot SHALL be ignored.
REQ-026 On rd_req_i with a READY slot, the READING slot SHALL become FREE, the READY slot SHALL become READING, and rd_new_o=1, rd_valid_o=1.
REQ-027 On rd_req_i with no READY slot but a READING slot, state SHALL be unchanged, the grant SHALL repeat the READING address, and rd_new_o=0, rd_valid_o=1.
REQ-028 On rd_req_i with neither a READY nor a READING slot, the grant SHALL carry rd_addr_o=START_ADDR, rd_new_o=0, rd_valid_o=0.
REQ-029 rd_gnt_o SHALL assert one cycle after rd_req_i.
REQ-030 Simultaneous events SHALL be applied in the order: done/abort, then write request, then read request. Consequences:
- a frame finished in cycle N SHALL be granted to a reader that requests in cycle N;
- wr_done_i with wr_req_i SHALL first commit the old slot, then allocate a new one.
REQ-031 With FRAMES_AMOUNT >= 3 a FREE slot SHALL always exist at a write request; the design SHALL nonetheless not corrupt state if none is free (no grant issued).
REQ-032 drop_cnt_o SHALL stop at its all-ones value.

Reset
REQ-033 On rst_n_i low, all slots SHALL be FREE immediately, asynchronously.
REQ-034 During reset: wr_gnt_o=0, rd_gnt_o=0, rd_new_o=0, rd_valid_o=0, wr_addr_o=START_ADDR, rd_addr_o=START_ADDR, drop_cnt_o=0.
REQ-035 A request pending when reset asserts SHALL be lost; no grant SHALL follow reset release without a new request.

Structure
REQ-036 slot_state_t (2-bit enum) and a slot-address function SHALL live in the shared package frame_buffer_pkg.
REQ-037 No sub-module is needed; the lowest-FREE priority encoder SHALL be an in-module function.

Verification
Bench parameters: START_ADDR=0x1000_0000, BYTES_PER_FRAME=0x1000, FRAMES_AMOUNT=3.
REQ-038 Reset, then rd_req -> rd_gnt next cycle with rd_valid=0, rd_new=0, rd_addr=0x1000_0000.
REQ-039 wr_req, wr_done, rd_req -> wr_addr=0x1000_0000, then rd_addr=0x1000_0000, rd_new=1; second rd_req -> same address, rd_new=0.
REQ-040 Writer completes three frames while the reader holds slot 0 -> writes go to 0x1000_1000, 0x1000_2000, 0x1000_1000; drop_cnt=2; next rd_req -> rd_addr=0x1000_1000.
REQ-041 wr_done and rd_req in the same cycle -> the reader receives the just-finished slot with rd_new=1.
REQ-042 wr_req, wr_abort, rd_req -> rd_valid=0; the next wr_req is granted 0x1000_0000 again.
REQ-043 Assert rst_n_i while slot 1 is WRITING and slot 0 is READING -> all outputs at reset values; the first wr_req after release is granted 0x1000_0000.
